// File: rtl/im_port_arbiter.sv
// Image-memory port arbiter: round-robin grant with bus lock and a
// burst limit that forces rotation when another requester is waiting.
module im_port_arbiter #(
  parameter int AW        = 20,
  parameter int DW        = 24,
  parameter int MAX_BURST = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [2:0]      wen,
  input  logic [3*AW-1:0] addr_i,
  input  logic [3*DW-1:0] wdata_i,
  output logic [2:0]      gnt,
  output logic [AW-1:0]   IM_A,
  output logic            IM_WEN,
  output logic [DW-1:0]   IM_D,
  input  logic [DW-1:0]   IM_Q,
  output logic [DW-1:0]   rdata,
  output logic [2:0]      rvalid,
  output logic            busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    rvalid_q, rvalid_d;

  logic [1:0] own;
  logic [1:0] lst;
  logic [1:0] p1;
  logic [1:0] p2;
  logic [1:0] pick;
  logic [2:0] own_oh;
  logic       issue;
  logic       others;

  function automatic logic [1:0] fix(input logic [1:0] i);
    return (i == 2'd3) ? 2'd0 : i;
  endfunction

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  always_comb begin
    own    = fix(owner_q);
    lst    = fix(last_q);
    p1     = nxt(lst);
    p2     = nxt(p1);
    own_oh = 3'(3'b001 << own);
    issue  = (state_q == OWN) && gnt_q[own] && req[own];
    others = |(req & ~own_oh);
    pick   = lst;
    if (req[p1])      pick = p1;
    else if (req[p2]) pick = p2;
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    rvalid_d = 3'b000;
    if (issue && !wen[own]) rvalid_d = own_oh;
    unique case (state_q)
      IDLE: begin
        gnt_d = 3'b000;
        if (|req) begin
          state_d = OWN;
          gnt_d   = 3'(3'b001 << pick);
          owner_d = pick;
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (!req[own]) begin
          state_d = IDLE;
          gnt_d   = 3'b000;
          last_d  = own;
        end else if (issue) begin
          if (cnt_q == CNT_LAST && others) begin
            // owner keeps req high and resumes after the others had a turn
            state_d = IDLE;
            gnt_d   = 3'b000;
            last_d  = own;
          end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= 3'b000;
      owner_q  <= 2'd0;
      last_q   <= 2'd2;
      cnt_q    <= '0;
      rvalid_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    IM_A   = '0;
    IM_D   = '0;
    IM_WEN = 1'b1;
    if (issue) begin
      IM_A   = addr_i[own*AW +: AW];
      IM_D   = wdata_i[own*DW +: DW];
      IM_WEN = ~wen[own];
    end
  end

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign rdata  = IM_Q;
  assign busy   = |gnt_q;

endmodule
